// File: rtl/sid_pot_bank.sv
// Parametrised POT/paddle digitiser: discharge window, per-channel charge-time counters, and
// all channels published together. Build with SID_POT_AVG_EN to average each result with the previous sample.
`timescale 1ns/1ps

// state        | meaning
// ST_DISCHARGE | discharge asserted, period counter runs DISCHARGE_TICKS ticks
// ST_CHARGE    | capacitors released, channel counters run 2^CNT_W ticks
module sid_pot_bank #(
  parameter int CHANNELS        = 2,
  parameter int CNT_W           = 8,
  parameter int DISCHARGE_TICKS = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic [CHANNELS-1:0]       charged,
  output logic                      discharge,
  output logic [CHANNELS*CNT_W-1:0] pot_val,
  output logic                      sample_valid
);

  localparam int CHG_TICKS = 2 ** CNT_W;
  localparam int PER_MAX   = (DISCHARGE_TICKS > CHG_TICKS) ? DISCHARGE_TICKS : CHG_TICKS;
  localparam int PER_W     = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;

  localparam logic [PER_W-1:0] DIS_LAST = PER_W'(DISCHARGE_TICKS - 1);
  localparam logic [PER_W-1:0] CHG_LAST = PER_W'(CHG_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {ST_DISCHARGE, ST_CHARGE} state_t;

  state_t                    state;
  logic [PER_W-1:0]          per_cnt;
  logic [CHANNELS-1:0]       sync_d, sync_q;
  logic [CHANNELS-1:0]       frozen, frozen_nxt;
  logic [CNT_W-1:0]          cnt     [CHANNELS];
  logic [CNT_W-1:0]          cnt_nxt [CHANNELS];
  logic [CHANNELS*CNT_W-1:0] pub_val;

`ifdef SID_POT_AVG_EN
  logic [CNT_W-1:0]          prev    [CHANNELS];
  logic [CNT_W:0]            avg_sum [CHANNELS];
`endif

  // The comparator inputs are asynchronous to clk; the synchroniser runs every clk, not per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d <= '0;
      sync_q <= '0;
    end else begin
      sync_d <= charged;
      sync_q <= sync_d;
    end
  end

  // Per-tick counting rule, using the synchronised level seen before the tick.
  always_comb begin
    frozen_nxt = frozen | sync_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (!sync_q[i] && !frozen[i] && (cnt[i] != CNT_MAX))
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
    end
  end

  // Published value includes the final charge tick.
  always_comb begin
    pub_val = '0;
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef SID_POT_AVG_EN
      avg_sum[i] = {1'b0, cnt_nxt[i]} + {1'b0, prev[i]};
      pub_val[i*CNT_W +: CNT_W] = avg_sum[i][CNT_W:1];
`else
      pub_val[i*CNT_W +: CNT_W] = cnt_nxt[i];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_DISCHARGE;
      per_cnt      <= '0;
      frozen       <= '0;
      discharge    <= 1'b1;
      pot_val      <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
`ifdef SID_POT_AVG_EN
        prev[i] <= '0;
`endif
      end
    end else begin
      sample_valid <= 1'b0;
      if (tick) begin
        case (state)
          ST_DISCHARGE: begin
            discharge <= 1'b1;
            if (per_cnt == DIS_LAST) begin
              state     <= ST_CHARGE;
              per_cnt   <= '0;
              frozen    <= '0;
              discharge <= 1'b0;
              for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
            end else begin
              per_cnt <= per_cnt + PER_W'(1);
            end
          end
          ST_CHARGE: begin
            frozen <= frozen_nxt;
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_nxt[i];
            if (per_cnt == CHG_LAST) begin
              pot_val      <= pub_val;
              sample_valid <= 1'b1;
              state        <= ST_DISCHARGE;
              per_cnt      <= '0;
              discharge    <= 1'b1;
`ifdef SID_POT_AVG_EN
              for (int i = 0; i < CHANNELS; i++) prev[i] <= cnt_nxt[i];
`endif
            end else begin
              per_cnt <= per_cnt + PER_W'(1);
            end
          end
          default: state <= ST_DISCHARGE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sid_pot_bank.sv
// Scoreboard bench for sid_pot_bank: default 2x8-bit instance and a 4x6-bit instance with a short discharge.
`timescale 1ns/1ps

module tb_sid_pot_bank;

  logic        clk;
  logic        rst_n_a, rst_n_b, tick;
  logic [1:0]  chg_a;
  logic [3:0]  chg_b;
  logic        dis_a, dis_b, sv_a, sv_b;
  logic [15:0] pot_a;
  logic [23:0] pot_b;

  sid_pot_bank dut_a (
    .clk(clk), .rst_n(rst_n_a), .tick(tick), .charged(chg_a),
    .discharge(dis_a), .pot_val(pot_a), .sample_valid(sv_a)
  );

  sid_pot_bank #(.CHANNELS(4), .CNT_W(6), .DISCHARGE_TICKS(10)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .tick(tick), .charged(chg_b),
    .discharge(dis_b), .pot_val(pot_b), .sample_valid(sv_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int fails   = 0;

  logic [15:0] q_a[$];
  logic [23:0] q_b[$];
  int prev_a [2];
  int prev_b [4];

  int tcount  = 0;
  int dis_cnt = 0;
  bit tick_run = 0;
  bit stall    = 0;

  int pulses_a = 0, last_tc_a = 0;
  int pulses_b = 0, last_tc_b = 0;
  logic [15:0] last_exp_a = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_a(input int r0, input int r1);
    int raw [2];
    int o;
    logic [15:0] v;
    raw[0] = r0; raw[1] = r1; v = '0;
    for (int i = 0; i < 2; i++) begin
      o = raw[i];
`ifdef SID_POT_AVG_EN
      o = (raw[i] + prev_a[i]) / 2;
      prev_a[i] = raw[i];
`endif
      v[i*8 +: 8] = o[7:0];
    end
    return v;
  endfunction

  function automatic logic [23:0] model_b(input int r0, input int r1, input int r2, input int r3);
    int raw [4];
    int o;
    logic [23:0] v;
    raw[0] = r0; raw[1] = r1; raw[2] = r2; raw[3] = r3; v = '0;
    for (int i = 0; i < 4; i++) begin
      o = raw[i];
`ifdef SID_POT_AVG_EN
      o = (raw[i] + prev_b[i]) / 2;
      prev_b[i] = raw[i];
`endif
      v[i*6 +: 6] = o[5:0];
    end
    return v;
  endfunction

  // One tick every 8 clk; tcount = ticks issued since restart. Discharge is sampled as the tick is issued.
  initial begin
    int div;
    div  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      if (!tick_run) begin
        tick = 1'b0;
        div  = 0;
      end else if (stall) begin
        tick = 1'b0;
      end else if (div == 7) begin
        tick = 1'b1;
        tcount++;
        if (dis_a && tcount <= 512) dis_cnt++;
        div = 0;
      end else begin
        tick = 1'b0;
        div++;
      end
    end
  end

  initial begin : mon_a
    logic [15:0] e;
    bit prev_sv;
    prev_sv = 0;
    forever begin
      @(negedge clk);
      if (sv_a) begin
        pulses_a++;
        last_tc_a = tcount;
        if (prev_sv) begin
          vectors++; fails++;
          $display("FAIL a_pulse_width: sample_valid high 2+ clk, expected 1");
        end
        if (q_a.size() == 0) begin
          vectors++; fails++;
          $display("FAIL a_unexpected_sample: got pot_val 0x%0h, expected no sample", pot_a);
        end else begin
          e = q_a.pop_front();
          check("a_pot_val", pot_a, e);
          last_exp_a = e;
        end
      end
      prev_sv = sv_a;
    end
  end

  initial begin : mon_b
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (sv_b) begin
        pulses_b++;
        last_tc_b = tcount;
        if (q_b.size() == 0) begin
          vectors++; fails++;
          $display("FAIL b_unexpected_sample: got pot_val 0x%0h, expected no sample", pot_b);
        end else begin
          e = q_b.pop_front();
          check("b_pot_val", pot_b, e);
        end
      end
    end
  end

  task automatic wait_tc(input int n);
    int guard;
    guard = 0;
    while (tcount < n && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    if (tcount < n) begin
      vectors++; fails++;
      $display("FAIL wait_tc: tick count %0d, expected to reach %0d", tcount, n);
    end
  endtask

  // Returns 4 clk after charge tick k (1-based) of a period starting at tick count p.
  task automatic at_charge(input int p, input int dis_ticks, input int k);
    wait_tc(p + dis_ticks + k);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_pulse(input bit is_b, input int n);
    int guard;
    guard = 0;
    while (((is_b ? pulses_b : pulses_a) < n) && guard < 6000) begin
      @(negedge clk);
      guard++;
    end
    if ((is_b ? pulses_b : pulses_a) < n) begin
      vectors++; fails++;
      $display("FAIL wait_pulse: pulses %0d, expected %0d", is_b ? pulses_b : pulses_a, n);
    end
  endtask

  task automatic restart_a;
    @(negedge clk);
    tcount   = 0;
    dis_cnt  = 0;
    rst_n_a  = 1'b1;
    tick_run = 1'b1;
  endtask

  initial begin
    int ps;
    rst_n_a = 1'b0; rst_n_b = 1'b0; chg_a = '0; chg_b = '0;
    for (int i = 0; i < 2; i++) prev_a[i] = 0;
    for (int i = 0; i < 4; i++) prev_b[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_discharge", dis_a, 1);
    check("rst_pot_val", pot_a, 0);
    check("rst_sample_valid", sv_a, 0);
    restart_a();

    // Period 1: ch0 charges after tick 99, ch1 never.
    q_a.push_back(model_a(99, 255));
    at_charge(0, 256, 99);
    chg_a[0] = 1'b1;
    wait_pulse(0, 1);
    check("p1_pulse_tick", last_tc_a, 512);
    check("p1_discharge_ticks", dis_cnt, 256);
    check("p1_discharge_after", dis_a, 1);

    // Period 2: both already high at charge entry.
    chg_a = 2'b11;
    q_a.push_back(model_a(0, 0));
    wait_pulse(0, 2);
    check("p2_pulse_tick", last_tc_a, 1024);

    // Period 3: ch0 pulses high then low, ch1 charges late.
    chg_a = 2'b00;
    q_a.push_back(model_a(40, 200));
    at_charge(1024, 256, 40);  chg_a[0] = 1'b1;
    at_charge(1024, 256, 60);  chg_a[0] = 1'b0;
    at_charge(1024, 256, 200); chg_a[1] = 1'b1;
    wait_pulse(0, 3);

    // Period 4: tick stalled for 1000 clk mid-charge while ch1 toggles.
    chg_a = 2'b00;
    q_a.push_back(model_a(30, 200));
    at_charge(1536, 256, 30);
    chg_a[0] = 1'b1;
    wait_tc(1536 + 256 + 120);
    @(negedge clk);
    stall = 1'b1;
    ps = pulses_a;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i % 37 == 0) chg_a[1] = ~chg_a[1];
    end
    chg_a[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_pulses", pulses_a, ps);
    check("stall_discharge", dis_a, 0);
    check("stall_pot_val", pot_a, last_exp_a);
    check("stall_tcount", tcount, 1536 + 256 + 120);
    stall = 1'b0;
    at_charge(1536, 256, 200);
    chg_a[1] = 1'b1;
    wait_pulse(0, 4);

    // Period 5: reset at charge tick 50, then a clean period.
    chg_a = 2'b00;
    at_charge(2048, 256, 50);
    rst_n_a = 1'b0;
    #1;
    check("midrst_discharge", dis_a, 1);
    check("midrst_pot_val", pot_a, 0);
    check("midrst_sample_valid", sv_a, 0);
    tick_run = 1'b0;
    for (int i = 0; i < 2; i++) prev_a[i] = 0;
    repeat (4) @(negedge clk);
    restart_a();
    q_a.push_back(model_a(77, 5));
    at_charge(0, 256, 5);  chg_a[1] = 1'b1;
    at_charge(0, 256, 77); chg_a[0] = 1'b1;
    wait_pulse(0, 5);
    check("postrst_pulse_tick", last_tc_a, 512);
    check("postrst_discharge_ticks", dis_cnt, 256);

    // Small instance: 4 channels, 6-bit, 10 discharge ticks.
    @(negedge clk);
    rst_n_a  = 1'b0;
    tick_run = 1'b0;
    chg_b    = 4'b0001;
    repeat (3) @(negedge clk);
    check("b_rst_discharge", dis_b, 1);
    tcount   = 0;
    rst_n_b  = 1'b1;
    tick_run = 1'b1;
    q_b.push_back(model_b(0, 13, 63, 63));
    at_charge(0, 10, 13); chg_b[1] = 1'b1;
    at_charge(0, 10, 63); chg_b[2] = 1'b1;
    wait_pulse(1, 1);
    check("b_pulse_tick", last_tc_b, 74);
    chg_b = 4'b0000;
    q_b.push_back(model_b(63, 63, 63, 63));
    wait_pulse(1, 2);
    check("b_pulse_tick2", last_tc_b, 148);

    repeat (4) @(negedge clk);
    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sid_pot_bank.md
Name: sid_pot_bank

Overview:
- Parametrised paddle/POT position digitiser for N analogue POT inputs.
- Successor to the fixed two-channel POTX/POTY scheme: channel count, counter width and discharge length are parameters, and a new-sample strobe is added.
- Sits between the pot_i_t/pot_o_t pad signals and the read register file.
- Each measurement period discharges the external capacitors, then counts the ticks each channel needs to charge, and publishes all channel results together.

Parameters:
- CHANNELS, 2, number of POT inputs.
- CNT_W, 8, counter/result width; the charge window is 2^CNT_W ticks.
- DISCHARGE_TICKS, 256, discharge window length in ticks (must be ≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-clk enable, asserted once per SID cycle (phi2); the FSM advances only on tick
- charged  in  CHANNELS  raw comparator inputs from pads, asynchronous
- discharge  out  1  pad discharge control, 1 = pull capacitors low
- pot_val  out  CHANNELS*CNT_W  results, channel i at bits [i*CNT_W +: CNT_W]
- sample_valid  out  1  one-clk strobe when pot_val updates

Behaviour:
- Reset, asynchronous on rst_n low, including mid-period:
  - state=DISCHARGE, period counter 0, all channel counters 0.
  - Synchroniser flops 0, discharge=1, pot_val=0, sample_valid=0.
- Synchroniser: charged passes through 2 clk flops (sync_q). It is not gated by tick. Its latency is invisible whenever ticks are ≥3 clk apart.
- DISCHARGE state:
  - discharge=1.
  - Period counter increments on each tick.
  - On the tick where the counter equals DISCHARGE_TICKS-1: move to CHARGE, clear the counter, clear all channel counters and frozen flags.
  - discharge=0 from the next clk.
- CHARGE state:
  - discharge=0.
  - On each tick, per channel i: if sync_q[i]=1, set frozen[i]. Otherwise, if frozen[i]=0 and cnt[i] < 2^CNT_W-1, increment cnt[i]. Evaluation uses the pre-tick sync_q value.
  - A channel already high at CHARGE entry reads 0.
  - A channel that never charges saturates at 2^CNT_W-1.
  - Once frozen, a channel stays frozen until the next CHARGE entry; later drops of charged are ignored.
- End of CHARGE: on the tick where the period counter equals 2^CNT_W-1:
  - That tick's increment rule is applied.
  - On the next clk: pot_val ← all cnt values (with that last tick included), sample_valid=1 for exactly 1 clk, state=DISCHARGE, period counter cleared.
- Period length is DISCHARGE_TICKS + 2^CNT_W ticks; the default is 512.
- pot_val holds between updates and is never partially updated: all channels change on the same clk.
- Counters are unsigned. The period counter is wide enough for max(DISCHARGE_TICKS, 2^CNT_W)-1. No wrap is possible because of saturation.
- With tick held low, nothing advances; only the synchronisers run.

Optional Feature:
- Macro: SID_POT_AVG_EN.
- When defined:
  - A per-channel previous-sample register (reset 0) is added.
  - At publication, pot_val[i] ← (cnt[i] + prev[i]) >> 1, computed in CNT_W+1 bits and truncated (round down), then prev[i] ← cnt[i].
  - sample_valid timing is unchanged.
- When undefined: pot_val = raw cnt and no prev registers exist.

Test Plan:
- Defaults, tick every 8 clk, charged[0] rises 4 clk after charge tick 99, charged[1] held 0 → after 512 ticks pot_val[7:0]=99, pot_val[15:8]=255, single sample_valid pulse, discharge high exactly 256 ticks.
- charged=2'b11 throughout → both channels 0. charged pulses 1→0 mid-charge on ch0 at tick 40 → ch0 still 40.
- Reset asserted at charge tick 50 → all outputs immediately at reset values. After release, the first sample_valid comes 512 ticks later; no stale pulse.
- CHANNELS=4, CNT_W=6, DISCHARGE_TICKS=10, charges at ticks 0/13/63/never → values 0/13/63/63, period 74 ticks.
- SID_POT_AVG_EN with ch0 raw sequence 100, 201, 201 → published 50, 150, 201.
- tick stalled low for 1000 clk mid-CHARGE with charged toggling → counters and state unchanged, no sample_valid.
